// File: rtl/cpu_pkg.sv
// Shared types and encodings for the instruction controller.
package cpu_pkg;

    localparam int unsigned REG_W  = 3;
    localparam int unsigned OPC_W  = 3;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned SH_W   = 2;
    localparam int unsigned IMM8_W = 8;

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WRITE_IMM = 3'd2,
        ST_GET_A     = 3'd3,
        ST_GET_B     = 3'd4,
        ST_EXEC      = 3'd5,
        ST_WRITE_REG = 3'd6
    } state_e;

    localparam logic [OPC_W-1:0] OP_MOV = 3'b110;
    localparam logic [OPC_W-1:0] OP_ALU = 3'b101;

    localparam logic [OP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [OP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [OP_W-1:0] ALU_AND = 2'b10;
    localparam logic [OP_W-1:0] ALU_MVN = 2'b11;

    // MOV sub-ops share the op field with the ALU group.
    localparam logic [OP_W-1:0] MOV_IMM = 2'b10;
    localparam logic [OP_W-1:0] MOV_REG = 2'b00;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rn;
        logic [REG_W-1:0] rd;
        logic [SH_W-1:0]  sh;
        logic [REG_W-1:0] rm;
    } instr_t;

endpackage

// File: rtl/cpu_controller_instr_decoder.sv
// Combinational field extraction, immediate sign extension and legality check.
module instr_decoder
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] ir_i,
    output instr_t           fields_o,
    output logic [WIDTH-1:0] sximm8_o,
    output logic             illegal_o
);

    always_comb begin
        fields_o.opcode = ir_i[15:13];
        fields_o.op     = ir_i[12:11];
        fields_o.rn     = ir_i[10:8];
        fields_o.rd     = ir_i[7:5];
        fields_o.sh     = ir_i[4:3];
        fields_o.rm     = ir_i[2:0];
    end

    assign sximm8_o = {{(WIDTH-IMM8_W){ir_i[IMM8_W-1]}}, ir_i[IMM8_W-1:0]};

    // Every ALU op is legal; MOV only has the immediate and register forms.
    always_comb begin
        illegal_o = 1'b1;
        if (ir_i[15:13] == OP_ALU) begin
            illegal_o = 1'b0;
        end else if (ir_i[15:13] == OP_MOV &&
                     (ir_i[12:11] == MOV_IMM || ir_i[12:11] == MOV_REG)) begin
            illegal_o = 1'b0;
        end
    end

endmodule

// File: rtl/vDFFE.sv
// Enabled register with asynchronous active-low clear.
module vDFFE #(
    parameter int unsigned N = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus Moore sequencer driving the register-file/ALU datapath.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             s,
    output logic             w,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             vsel,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       ALUop,
    output logic [1:0]       shift,
    output logic [WIDTH-1:0] datapath_in
);

    logic [WIDTH-1:0] ir_q;
    instr_t           f;
    logic             illegal;
    state_e           state_q, state_d;

    logic is_mov_imm, is_mov_reg, is_mvn, is_cmp;

    // IR only accepts a new word while idle.
    vDFFE #(.N(WIDTH)) u_ir (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (load & w),
        .d_i    (in),
        .q_o    (ir_q)
    );

    instr_decoder #(.WIDTH(WIDTH)) u_dec (
        .ir_i      (ir_q),
        .fields_o  (f),
        .sximm8_o  (datapath_in),
        .illegal_o (illegal)
    );

    assign is_mov_imm = (f.opcode == OP_MOV) && (f.op == MOV_IMM);
    assign is_mov_reg = (f.opcode == OP_MOV) && (f.op == MOV_REG);
    assign is_mvn     = (f.opcode == OP_ALU) && (f.op == ALU_MVN);
    assign is_cmp     = (f.opcode == OP_ALU) && (f.op == ALU_SUB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        w        = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        vsel     = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        ALUop    = ALU_ADD;
        shift    = f.sh;

        unique case (state_q)
            ST_WAIT: begin
                w = 1'b1;
                if (s) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (illegal)                     state_d = ST_WAIT;
                else if (is_mov_imm)             state_d = ST_WRITE_IMM;
                else if (is_mov_reg || is_mvn)   state_d = ST_GET_B;
                else                             state_d = ST_GET_A;
            end
            ST_WRITE_IMM: begin
                writenum = f.rn;
                vsel     = 1'b1;
                write    = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_GET_A: begin
                readnum = f.rn;
                loada   = 1'b1;
                state_d = ST_GET_B;
            end
            ST_GET_B: begin
                readnum = f.rm;
                loadb   = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // MOV reg rides the adder with A forced to zero.
                ALUop = is_mov_reg ? ALU_ADD : f.op;
                asel  = is_mov_reg || is_mvn;
                if (is_cmp) begin
                    loads   = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    loadc   = 1'b1;
                    state_d = ST_WRITE_REG;
                end
            end
            ST_WRITE_REG: begin
                writenum = f.rd;
                write    = 1'b1;
                state_d  = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed check of the controller's per-state control vector and latencies.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load, s;
    logic        w, write, loada, loadb, loadc, loads, vsel, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  ALUop, shift;
    logic [15:0] datapath_in;

    int n_cmp = 0;
    int n_err = 0;

    cpu_controller #(.WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .load        (load),
        .s           (s),
        .w           (w),
        .readnum     (readnum),
        .writenum    (writenum),
        .write       (write),
        .loada       (loada),
        .loadb       (loadb),
        .loadc       (loadc),
        .loads       (loads),
        .vsel        (vsel),
        .asel        (asel),
        .bsel        (bsel),
        .ALUop       (ALUop),
        .shift       (shift),
        .datapath_in (datapath_in)
    );

    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {w, readnum, writenum, write, loada, loadb, loadc, loads,
                  vsel, asel, bsel, ALUop, shift};

    // Expected vector: w, readnum, writenum, write, loada, loadb, loadc, loads, vsel, asel, ALUop, shift (bsel always 0).
    function automatic logic [18:0] ctl(input logic we, input logic [2:0] rn, input logic [2:0] wn,
                                        input logic wr, input logic la, input logic lb, input logic lc,
                                        input logic ls, input logic vs, input logic asl,
                                        input logic [1:0] alu, input logic [1:0] sh);
        return {we, rn, wn, wr, la, lb, lc, ls, vs, asl, 1'b0, alu, sh};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; in = '0; load = 1'b0; s = 1'b0;
        #3;
        chk("reset_ctl", 32'(obs), 32'(ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
        chk("reset_dp", 32'(datapath_in), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("idle_wait", 32'(obs), 32'(ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));

        // MOV R0,#7 with load and s together
        in = 16'hD007; load = 1'b1; s = 1'b1;
        step(); load = 1'b0; s = 1'b0;
        chk("movi7_decode", 32'(obs), 32'(ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
        chk("movi7_dp", 32'(datapath_in), 32'h0007);
        step();
        chk("movi7_write", 32'(obs), 32'(ctl(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00)));
        step();
        chk("movi7_done", 32'(w), 32'h1);

        // MOV R1,#-2
        in = 16'hD1FE; load = 1'b1; s = 1'b1;
        step(); load = 1'b0; s = 1'b0;
        chk("movim2_decode", 32'(obs), 32'(ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11)));
        chk("movim2_dp", 32'(datapath_in), 32'hFFFE);
        step();
        chk("movim2_write", 32'(obs), 32'(ctl(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b11)));
        step();
        chk("movim2_done", 32'(obs), 32'(ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11)));

        // ADD R2,R1,R0,LSL#1 while a stray load of 0xD0FF is held high
        in = 16'hA148; load = 1'b1; s = 1'b1;
        step(); s = 1'b0; in = 16'hD0FF;
        chk("add_decode", 32'(obs), 32'(ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01)));
        step();
        chk("add_get_a", 32'(obs), 32'(ctl(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01)));
        step();
        chk("add_get_b", 32'(obs), 32'(ctl(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01)));
        step();
        chk("add_exec", 32'(obs), 32'(ctl(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01)));
        chk("add_dp_kept", 32'(datapath_in), 32'h0048);
        step();
        chk("add_write", 32'(obs), 32'(ctl(0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01)));
        step(); load = 1'b0;
        chk("add_done", 32'(obs), 32'(ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01)));

        // CMP R0,R0 with s held high throughout
        in = 16'hA800; load = 1'b1; s = 1'b1;
        step(); load = 1'b0;
        chk("cmp_decode", 32'(obs), 32'(ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
        step();
        chk("cmp_get_a", 32'(obs), 32'(ctl(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
        step();
        chk("cmp_get_b", 32'(obs), 32'(ctl(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00)));
        step();
        chk("cmp_exec", 32'(obs), 32'(ctl(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00)));
        step();
        chk("cmp_done", 32'(w), 32'h1);
        step(); s = 1'b0;
        chk("cmp_restart", 32'(obs), 32'(ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
        step(); step(); step(); step();
        chk("cmp_restart_done", 32'(w), 32'h1);

        // MVN R3,R0 skips GET_A
        in = 16'hB860; load = 1'b1; s = 1'b1;
        step(); load = 1'b0; s = 1'b0;
        chk("mvn_decode", 32'(obs), 32'(ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
        step();
        chk("mvn_get_b", 32'(obs), 32'(ctl(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00)));
        step();
        chk("mvn_exec", 32'(obs), 32'(ctl(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2'b11, 2'b00)));
        step();
        chk("mvn_write", 32'(obs), 32'(ctl(0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
        step();
        chk("mvn_done", 32'(w), 32'h1);

        // MOV R5,R2,LSR#1
        in = 16'hC0B2; load = 1'b1; s = 1'b1;
        step(); load = 1'b0; s = 1'b0;
        step();
        chk("movr_get_b", 32'(obs), 32'(ctl(0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b10)));
        step();
        chk("movr_exec", 32'(obs), 32'(ctl(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2'b00, 2'b10)));
        step();
        chk("movr_write", 32'(obs), 32'(ctl(0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10)));
        step();
        chk("movr_done", 32'(w), 32'h1);

        // Illegal opcode 111
        in = 16'hE000; load = 1'b1; s = 1'b1;
        step(); load = 1'b0; s = 1'b0;
        chk("ill_decode", 32'(obs), 32'(ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
        step();
        chk("ill_done", 32'(obs), 32'(ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));

        // Asynchronous reset in the middle of an ADD
        in = 16'hA148; load = 1'b1; s = 1'b1;
        step(); load = 1'b0; s = 1'b0;
        step(); step();
        chk("rst_pre_get_b", 32'(obs), 32'(ctl(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01)));
        #1 reset = 1'b0;
        #1;
        chk("rst_abort", 32'(obs), 32'(ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
        chk("rst_abort_dp", 32'(datapath_in), 32'h0);
        step();
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("rst_hold1", 32'(obs), 32'(ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));
        step();
        chk("rst_hold2", 32'(obs), 32'(ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
